csr_irq_file: RTL and testbench

Parametrised machine-mode CSR file with a level-sensitive interrupt controller for the 3-stage core. It sits beside the execute stage and serves CSRRW/CSRRS/CSRRC reads and writes. It arbitrates timer, external and NUM_PLAT platform interrupt lines, and on a trap or MRET issues a single-cycle PC redirect to the fetch stage. It also implements direct/vectored mtvec, the mstatus MIE/MPIE stack, and 64-bit mcycle/minstret counters.

---
 rtl/csr_irq_file.sv | 169 ++++++++++++++++
 tb/tb_csr_irq_file.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/csr_irq_file.sv
// Machine-mode CSR file with level-sensitive interrupt arbitration and trap/MRET redirect.
// Reads and redirect are combinational; state updates on the next edge; no backpressure.
module csr_irq_file #(
  parameter int unsigned     DW          = 32,
  parameter int unsigned     ADDRW       = 12,
  parameter int unsigned     NUM_PLAT    = 4,
  parameter logic [DW-1:0]   RESET_MTVEC = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                t_intr_i,
  input  logic                e_intr_i,
  input  logic [NUM_PLAT-1:0] plat_intr_i,
  input  logic                instr_valid_i,
  input  logic [DW-1:0]       pc_i,
  input  logic [1:0]          csr_op_i,
  input  logic [ADDRW-1:0]    csr_addr_i,
  input  logic [DW-1:0]       csr_wdata_i,
  input  logic                is_mret_i,
  output logic [DW-1:0]       csr_rdata_o,
  output logic                csr_illegal_o,
  output logic                redirect_o,
  output logic [DW-1:0]       redirect_pc_o
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [ADDRW-1:0] A_MSTATUS   = ADDRW'(12'h300);
  localparam logic [ADDRW-1:0] A_MIE       = ADDRW'(12'h304);
  localparam logic [ADDRW-1:0] A_MTVEC     = ADDRW'(12'h305);
  localparam logic [ADDRW-1:0] A_MEPC      = ADDRW'(12'h341);
  localparam logic [ADDRW-1:0] A_MCAUSE    = ADDRW'(12'h342);
  localparam logic [ADDRW-1:0] A_MIP       = ADDRW'(12'h344);
  localparam logic [ADDRW-1:0] A_MCYCLE    = ADDRW'(12'hB00);
  localparam logic [ADDRW-1:0] A_MCYCLEH   = ADDRW'(12'hB80);
  localparam logic [ADDRW-1:0] A_MINSTRET  = ADDRW'(12'hB02);
  localparam logic [ADDRW-1:0] A_MINSTRETH = ADDRW'(12'hB82);

  localparam logic [DW-1:0] MIE_MASK =
      DW'(32'h0000_0880) | (DW'((64'd1 << NUM_PLAT) - 64'd1) << 16);

  logic          mstat_mie, mstat_mpie;
  logic [DW-1:0] mie_q, mtvec_q, mepc_q, mcause_q, mip_q;
  logic [63:0]   mcycle_q, minstret_q;
  logic [63:0]   mcycle_nxt, minstret_nxt;

  logic [DW-1:0] old_val, wval, pend, mepc_rd, tvec_base, trap_pc, mip_nxt;
  logic          impl, op_none, illegal, wr_en, irq_take, mret_take, retire;
  logic [4:0]    irq_cause;

  always_comb begin
    old_val = '0;
    impl    = 1'b1;
    case (csr_addr_i)
      A_MSTATUS:   old_val = DW'(32'h1800) | (DW'(mstat_mpie) << 7) | (DW'(mstat_mie) << 3);
      A_MIE:       old_val = mie_q;
      A_MTVEC:     old_val = mtvec_q;
      A_MEPC:      old_val = mepc_rd;
      A_MCAUSE:    old_val = mcause_q;
      A_MIP:       old_val = mip_q;
      A_MCYCLE:    old_val = mcycle_q[31:0];
      A_MCYCLEH:   old_val = mcycle_q[63:32];
      A_MINSTRET:  old_val = minstret_q[31:0];
      A_MINSTRETH: old_val = minstret_q[63:32];
      default:     impl    = 1'b0;
    endcase
  end

  assign mepc_rd = mepc_q & ~DW'(3);
  assign op_none = (csr_op_i == OP_NONE);
  assign illegal = !op_none && (!impl || (csr_op_i == OP_RW && csr_addr_i == A_MIP));

  always_comb begin
    wval = old_val;
    case (csr_op_i)
      OP_RW:   wval = csr_wdata_i;
      OP_RS:   wval = old_val | csr_wdata_i;
      OP_RC:   wval = old_val & ~csr_wdata_i;
      default: wval = old_val;
    endcase
  end

  // Pending interrupts come from the registered mip, so a source is seen one cycle late.
  assign pend      = mip_q & mie_q;
  assign irq_take  = instr_valid_i && mstat_mie && (|pend);
  assign mret_take = instr_valid_i && is_mret_i && !irq_take;
  assign retire    = instr_valid_i && !irq_take;
  assign wr_en     = instr_valid_i && !irq_take && !illegal && !op_none &&
                     (csr_op_i == OP_RW || csr_wdata_i != '0);

  always_comb begin
    irq_cause = 5'd0;
    for (int k = int'(NUM_PLAT) - 1; k >= 0; k--) begin
      if (pend[16+k]) irq_cause = 5'(16 + k);
    end
    if (pend[7])  irq_cause = 5'd7;
    if (pend[11]) irq_cause = 5'd11;
  end

  assign tvec_base = mtvec_q & ~DW'(3);
  assign trap_pc   = mtvec_q[0] ? tvec_base + (DW'(irq_cause) << 2) : tvec_base;
  assign mip_nxt   = (DW'(t_intr_i) << 7) | (DW'(e_intr_i) << 11) | (DW'(plat_intr_i) << 16);

  assign redirect_o    = rst_i && (irq_take || mret_take);
  assign redirect_pc_o = !rst_i   ? '0 :
                         irq_take ? trap_pc :
                         mret_take ? mepc_rd : '0;
  assign csr_illegal_o = rst_i && illegal;
  assign csr_rdata_o   = (rst_i && !op_none && impl) ? old_val : '0;

  // A CSR write to either half replaces the increment for the full 64-bit counter.
  always_comb begin
    mcycle_nxt   = mcycle_q + 64'd1;
    minstret_nxt = minstret_q + (retire ? 64'd1 : 64'd0);
    if (wr_en) begin
      case (csr_addr_i)
        A_MCYCLE:    mcycle_nxt   = {mcycle_q[63:32], wval};
        A_MCYCLEH:   mcycle_nxt   = {wval, mcycle_q[31:0]};
        A_MINSTRET:  minstret_nxt = {minstret_q[63:32], wval};
        A_MINSTRETH: minstret_nxt = {wval, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mstat_mie  <= 1'b0;
      mstat_mpie <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= RESET_MTVEC;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mip_q      <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mip_q      <= mip_nxt;
      mcycle_q   <= mcycle_nxt;
      minstret_q <= minstret_nxt;
      if (irq_take) begin
        mepc_q     <= pc_i;
        mcause_q   <= {1'b1, {(DW-6){1'b0}}, irq_cause};
        mstat_mpie <= mstat_mie;
        mstat_mie  <= 1'b0;
      end else if (mret_take) begin
        mstat_mie  <= mstat_mpie;
        mstat_mpie <= 1'b1;
      end else if (wr_en) begin
        case (csr_addr_i)
          A_MSTATUS: begin
            mstat_mie  <= wval[3];
            mstat_mpie <= wval[7];
          end
          A_MIE:    mie_q    <= wval & MIE_MASK;
          // Reserved MODE encodings (2, 3) leave the current mode in place.
          A_MTVEC:  mtvec_q  <= {wval[DW-1:2], (wval[1] ? mtvec_q[1:0] : wval[1:0])};
          A_MEPC:   mepc_q   <= wval;
          A_MCAUSE: mcause_q <= wval;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_irq_file.sv
// Directed bench for csr_irq_file: reset, CSR ops, trap priority, MRET, collisions, counters.
module tb_csr_irq_file;
  localparam int          NP       = 4;
  localparam logic [31:0] RST_TVEC = 32'h0000_0100;

  localparam logic [1:0]  RW = 2'b01, RS = 2'b10, RC = 2'b11;
  localparam logic [11:0] MSTATUS = 12'h300, MIE = 12'h304, MTVEC = 12'h305, MEPC = 12'h341,
                          MCAUSE = 12'h342, MIP = 12'h344, MCYCLE = 12'hB00, MCYCLEH = 12'hB80,
                          MINSTRET = 12'hB02, MINSTRETH = 12'hB82;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          t_intr_i = 1'b0, e_intr_i = 1'b0;
  logic [NP-1:0] plat_intr_i = '0;
  logic          instr_valid_i = 1'b0;
  logic [31:0]   pc_i = '0;
  logic [1:0]    csr_op_i = '0;
  logic [11:0]   csr_addr_i = '0;
  logic [31:0]   csr_wdata_i = '0;
  logic          is_mret_i = 1'b0;
  logic [31:0]   csr_rdata_o;
  logic          csr_illegal_o;
  logic          redirect_o;
  logic [31:0]   redirect_pc_o;

  int checks = 0;
  int errors = 0;

  always #50 clk_i = ~clk_i;

  csr_irq_file #(.DW(32), .ADDRW(12), .NUM_PLAT(NP), .RESET_MTVEC(RST_TVEC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .t_intr_i(t_intr_i), .e_intr_i(e_intr_i),
    .plat_intr_i(plat_intr_i), .instr_valid_i(instr_valid_i), .pc_i(pc_i),
    .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
    .is_mret_i(is_mret_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Side-effect-free read: RS with zero operand, no valid instruction.
  task automatic csr_rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    instr_valid_i = 1'b0;
    csr_op_i      = RS;
    csr_addr_i    = addr;
    csr_wdata_i   = '0;
    #1;
    chk(tag, csr_rdata_o, exp);
    csr_op_i = 2'b00;
  endtask

  task automatic csr_wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data);
    instr_valid_i = 1'b1;
    csr_op_i      = op;
    csr_addr_i    = addr;
    csr_wdata_i   = data;
    tick();
    instr_valid_i = 1'b0;
    csr_op_i      = 2'b00;
    csr_wdata_i   = '0;
  endtask

  initial begin
    // Reset: outputs forced quiet even with an MRET and a read presented.
    instr_valid_i = 1'b1; is_mret_i = 1'b1; csr_op_i = RS; csr_addr_i = MSTATUS;
    #1;
    chk("rst_redirect", {31'b0, redirect_o}, 32'h0);
    chk("rst_rdata", csr_rdata_o, 32'h0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b1; instr_valid_i = 1'b0; is_mret_i = 1'b0; csr_op_i = 2'b00;

    csr_rd(MSTATUS,   32'h0000_1800, "rst_mstatus");
    csr_rd(MIE,       32'h0,         "rst_mie");
    csr_rd(MTVEC,     RST_TVEC,      "rst_mtvec");
    csr_rd(MEPC,      32'h0,         "rst_mepc");
    csr_rd(MCAUSE,    32'h0,         "rst_mcause");
    csr_rd(MIP,       32'h0,         "rst_mip");
    csr_rd(MCYCLE,    32'h0,         "rst_mcycle");
    csr_rd(MCYCLEH,   32'h0,         "rst_mcycleh");
    csr_rd(MINSTRET,  32'h0,         "rst_minstret");
    csr_rd(MINSTRETH, 32'h0,         "rst_minstreth");

    // Illegal accesses
    csr_op_i = RS; csr_addr_i = 12'h123; #1;
    chk("unimpl_rdata", csr_rdata_o, 32'h0);
    chk("unimpl_illegal", {31'b0, csr_illegal_o}, 32'h1);
    csr_op_i = RW; csr_addr_i = MIP; #1;
    chk("mip_rw_illegal", {31'b0, csr_illegal_o}, 32'h1);
    csr_op_i = RS; csr_addr_i = MIE; #1;
    chk("mie_rs_legal", {31'b0, csr_illegal_o}, 32'h0);
    csr_op_i = 2'b00;

    // Set/clear ops on mie
    csr_wr(RW, MIE, 32'hFFFF_FFFF);
    csr_rd(MIE, 32'h000F_0880, "mie_rw_mask");
    csr_wr(RC, MIE, 32'h0000_0080);
    csr_rd(MIE, 32'h000F_0800, "mie_rc");
    csr_wr(RS, MIE, 32'h0);
    csr_rd(MIE, 32'h000F_0800, "mie_rs_zero");
    csr_wr(RW, MIE, 32'h0);

    // Timer trap, vectored mode
    csr_wr(RW, MTVEC, 32'h0000_1001);
    csr_rd(MTVEC, 32'h0000_1001, "mtvec_vec");
    csr_wr(RW, MTVEC, 32'h0000_1003);
    csr_rd(MTVEC, 32'h0000_1001, "mtvec_bad_mode");
    csr_wr(RW, MIE, 32'h0000_0080);
    csr_wr(RW, MSTATUS, 32'h0000_0008);
    csr_rd(MSTATUS, 32'h0000_1808, "mstatus_mie_set");
    t_intr_i = 1'b1; instr_valid_i = 1'b1; pc_i = 32'h1FC; #1;
    chk("tmr_no_redirect_same_cycle", {31'b0, redirect_o}, 32'h0);
    tick();
    pc_i = 32'h200; #1;
    chk("tmr_redirect", {31'b0, redirect_o}, 32'h1);
    chk("tmr_redirect_pc", redirect_pc_o, 32'h0000_101C);
    tick();
    t_intr_i = 1'b0;
    csr_rd(MEPC,    32'h0000_0200, "tmr_mepc");
    csr_rd(MCAUSE,  32'h8000_0007, "tmr_mcause");
    csr_rd(MSTATUS, 32'h0000_1880, "tmr_mstatus");

    // Priority in direct mode, then MRET and retake
    csr_wr(RW, MTVEC, 32'h0000_0400);
    csr_wr(RW, MIE, 32'h000F_0880);
    csr_wr(RW, MSTATUS, 32'h0000_0008);
    e_intr_i = 1'b1; t_intr_i = 1'b1; plat_intr_i = 4'b0100;
    tick();
    instr_valid_i = 1'b1; pc_i = 32'h300; #1;
    chk("prio_redirect", {31'b0, redirect_o}, 32'h1);
    chk("prio_redirect_pc", redirect_pc_o, 32'h0000_0400);
    tick();
    e_intr_i = 1'b0;
    csr_rd(MCAUSE, 32'h8000_000B, "prio_mcause");
    csr_rd(MEPC,   32'h0000_0300, "prio_mepc");
    tick();
    instr_valid_i = 1'b1; is_mret_i = 1'b1; pc_i = 32'h404; #1;
    chk("mret_redirect", {31'b0, redirect_o}, 32'h1);
    chk("mret_redirect_pc", redirect_pc_o, 32'h0000_0300);
    tick();
    is_mret_i = 1'b0; pc_i = 32'h300; #1;
    chk("retake_redirect", {31'b0, redirect_o}, 32'h1);
    chk("retake_redirect_pc", redirect_pc_o, 32'h0000_0400);
    tick();
    csr_rd(MCAUSE, 32'h8000_0007, "retake_mcause");

    // Interrupt colliding with MRET
    csr_wr(RW, MSTATUS, 32'h0000_0008);
    instr_valid_i = 1'b1; is_mret_i = 1'b1; pc_i = 32'h500; #1;
    chk("coll_mret_redirect_pc", redirect_pc_o, 32'h0000_0400);
    tick();
    is_mret_i = 1'b0;
    csr_rd(MEPC,    32'h0000_0500, "coll_mret_mepc");
    csr_rd(MSTATUS, 32'h0000_1880, "coll_mret_mstatus");

    // Interrupt colliding with a CSRRW to mtvec
    csr_wr(RW, MSTATUS, 32'h0000_0008);
    instr_valid_i = 1'b1; csr_op_i = RW; csr_addr_i = MTVEC; csr_wdata_i = 32'h800; pc_i = 32'h600; #1;
    chk("coll_wr_redirect", {31'b0, redirect_o}, 32'h1);
    tick();
    instr_valid_i = 1'b0; csr_op_i = 2'b00;
    csr_rd(MTVEC, 32'h0000_0400, "coll_wr_mtvec");
    csr_rd(MEPC,  32'h0000_0600, "coll_wr_mepc");
    t_intr_i = 1'b0; plat_intr_i = '0;
    csr_wr(RW, MIE, 32'h0000_0080);

    // mcycle carry into the high word
    csr_wr(RW, MCYCLEH, 32'h0);
    csr_wr(RW, MCYCLE, 32'hFFFF_FFFF);
    csr_rd(MCYCLE, 32'hFFFF_FFFF, "mcycle_written");
    tick();
    csr_rd(MCYCLE,  32'h0, "mcycle_wrap_lo");
    csr_rd(MCYCLEH, 32'h1, "mcycle_carry_hi");

    // minstret: 10 valid instructions, the second one trapped
    t_intr_i = 1'b1;
    csr_wr(RW, MINSTRETH, 32'h0);
    csr_wr(RW, MINSTRET, 32'h100);
    csr_wr(RW, MSTATUS, 32'h0000_0008);
    instr_valid_i = 1'b1; pc_i = 32'h700; #1;
    chk("instret_trap_redirect", {31'b0, redirect_o}, 32'h1);
    tick();
    for (int i = 0; i < 8; i++) begin
      instr_valid_i = 1'b1;
      tick();
    end
    instr_valid_i = 1'b0; t_intr_i = 1'b0;
    csr_rd(MINSTRET,  32'h0000_0109, "minstret_count");
    csr_rd(MINSTRETH, 32'h0,         "minstreth_count");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
